imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes the instruction memory read by the pipelined core's fetch stage. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues one write per word to sequential word addresses starting at 0. It holds the core in reset until the load finishes. It sits between a host byte source (UART RX or testbench) and the instruction memory write port.

## Interface
- `DEPTH_WORDS`, 64: instruction memory depth in words.
- `ADDR_W`, $clog2(DEPTH_WORDS): word-address width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled in IDLE, DONE and ERR only.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word to write.
- `core_hold`  out  1  high while the core must stay in reset.
- `done`  out  1  load completed successfully.
- `error`  out  1  load aborted: length or checksum failure.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4N payload bytes, then a checksum byte when `LOADER_CSUM_EN` is defined. Each word's first byte goes to [7:0].
- A byte is accepted on a rising edge where `byte_valid && byte_ready`. `byte_data` is ignored when no byte is accepted.
- States: IDLE, LEN0, LEN1, DATA, CSUM, FIN, DONE, ERR.
- IDLE/DONE/ERR: `byte_ready`=0. When `start`=1, go to LEN0. This clears `done` and `error`, sets `core_hold`, and zeroes the word address, byte counter and checksum accumulator.
- LEN0: accept a byte into len[7:0]. LEN1: accept a byte into len[15:8], then:
  - len > DEPTH_WORDS: go to ERR. No write is issued.
  - len == 0: go to CSUM, or to FIN when checksum is compiled out.
  - otherwise: go to DATA.
- DATA: a 2-bit byte counter shifts each accepted byte into an assembly register. The checksum accumulator is XOR-ed with every payload byte.
- On the 4th byte of a word, the assembled word and current address are registered onto `imem_wdata`/`imem_addr`, and `imem_we` pulses the next cycle. The address then increments. After word N-1 the loader goes to CSUM or FIN.
- CSUM: accept one byte. If it equals the accumulator, go to FIN; otherwise go to ERR.
- FIN: one cycle with `byte_ready`=0, then DONE.
- DONE: `done`=1, `core_hold`=0. ERR: `error`=1, `core_hold`=1.
- `start` in LEN0/LEN1/DATA/CSUM/FIN is ignored.
- Address never wraps. The length check guarantees the maximum address is DEPTH_WORDS-1.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=1, `done`=0, `error`=0. Reset takes effect immediately (async) and is released synchronously.
- `byte_ready` is registered from state: 1 in LEN0, LEN1, DATA and CSUM, 0 elsewhere. It stays 1 in DATA during a write pulse, so back-to-back bytes sustain 1 byte/cycle. The word write overlaps the next word's first byte.
- Write latency: `imem_we` is high exactly one cycle, the cycle after the 4th byte of a word is accepted. `imem_addr`/`imem_wdata` are stable in that cycle.
- The last `imem_we` precedes the rise of `done` and the fall of `core_hold` by at least one cycle (FIN guarantees this). The core never fetches while a write is pending.
- `done`/`error` rise one cycle after entering DONE/ERR and hold until `start` or reset.
- Reset mid-load: memory contents already written are left as-is. No `imem_we` is issued after reset assertion. The next load restarts at address 0.

## Configuration
- `LOADER_CSUM_EN` defined: the CSUM state exists and the stream ends with an XOR-of-payload checksum byte. A mismatch leads to ERR with `core_hold` kept high. Words already written remain.
- Not defined: no CSUM state and no accumulator. After the last word (or len==0) the loader goes straight to FIN. No trailing byte is consumed, and `error` is raised only by the length check.

## Test plan
- Nominal load (CSUM_EN): start; bytes 02 00 13 05 10 00 93 05 20 00 B0 back-to-back.
  - Required: write addr0=0x00100513 and write addr1=0x00200593, each one cycle.
  - Then `done`=1, `core_hold`=0, `error`=0.
- Bad checksum: same stream with final byte B1.
  - Required: both writes occur, then `error`=1, `done`=0, `core_hold`=1.
- Oversize length: bytes 41 00 (65 > 64).
  - Required: ERR right after the second byte, zero `imem_we` pulses, and `byte_ready`=0 afterwards.
- Handshake: `byte_valid` high in IDLE (no accept, `byte_ready`=0), then the nominal stream with random 0–3 idle cycles between bytes.
  - Required: writes are identical to the nominal case, and no byte is dropped or duplicated.
- Reset mid-load: assert `reset` after 6 bytes of the nominal stream.
  - Required: all outputs return to reset values immediately.
  - Then a fresh start plus the nominal stream writes addr0/addr1 correctly.
- Empty load: bytes 00 00 00 (CSUM_EN) or 00 00 (without).
  - Required: no writes, then `done`=1 and `core_hold`=0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: LEN_LO, LEN_HI, 4*N little-endian payload bytes.
// Define LOADER_CSUM_EN to require a trailing XOR-of-payload checksum byte.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA,
`ifdef LOADER_CSUM_EN
    CSUM,
`endif
    FIN, DONE, ERR
  } state_e;

`ifdef LOADER_CSUM_EN
  localparam state_e TAIL       = CSUM;
  localparam logic   TAIL_READY = 1'b1;
`else
  localparam state_e TAIL       = FIN;
  localparam logic   TAIL_READY = 1'b0;
`endif

  state_e              state_q;
  logic [15:0]         len_q;
  logic [23:0]         asm_q;
  logic [1:0]          cnt_q;
  logic [ADDR_W-1:0]   waddr_q;
`ifdef LOADER_CSUM_EN
  logic [7:0]          csum_q;
`endif
  logic                byte_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                core_hold_q;
  logic                done_q;
  logic                error_q;

  logic                accept_d;
  logic [15:0]         len_d;
  logic [31:0]         word_d;
  logic                last_d;

  assign accept_d = byte_valid && byte_ready_q;
  assign len_d    = {byte_data, len_q[7:0]};
  assign word_d   = {byte_data, asm_q};
  assign last_d   = (16'(waddr_q) + 16'd1) == len_q;

  // byte_ready is loaded with the readiness of the state being entered, so it
  // always matches state_q and accept_d never sees a stale value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      asm_q        <= '0;
      cnt_q        <= '0;
      waddr_q      <= '0;
`ifdef LOADER_CSUM_EN
      csum_q       <= '0;
`endif
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q      <= LEN0;
            byte_ready_q <= 1'b1;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            waddr_q      <= '0;
            imem_addr_q  <= '0;
            cnt_q        <= '0;
`ifdef LOADER_CSUM_EN
            csum_q       <= '0;
`endif
          end else if (state_q == DONE) begin
            done_q      <= 1'b1;
            core_hold_q <= 1'b0;
          end else if (state_q == ERR) begin
            error_q <= 1'b1;
          end
        end
        LEN0: begin
          if (accept_d) begin
            len_q[7:0] <= byte_data;
            state_q    <= LEN1;
          end
        end
        LEN1: begin
          if (accept_d) begin
            len_q[15:8] <= byte_data;
            if (len_d > 16'(DEPTH_WORDS)) begin
              state_q      <= ERR;
              byte_ready_q <= 1'b0;
            end else if (len_d == 16'd0) begin
              state_q      <= TAIL;
              byte_ready_q <= TAIL_READY;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_d) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= {byte_data, asm_q[23:8]};
`ifdef LOADER_CSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
            // The write issues while the next word's first byte may already be arriving.
            if (cnt_q == 2'd3) begin
              imem_wdata_q <= word_d;
              imem_addr_q  <= waddr_q;
              imem_we_q    <= 1'b1;
              waddr_q      <= waddr_q + ADDR_W'(1);
              if (last_d) begin
                state_q      <= TAIL;
                byte_ready_q <= TAIL_READY;
              end
            end
          end
        end
`ifdef LOADER_CSUM_EN
        CSUM: begin
          if (accept_d) begin
            byte_ready_q <= 1'b0;
            state_q      <= (byte_data == csum_q) ? FIN : ERR;
          end
        end
`endif
        FIN: begin
          state_q <= DONE;
        end
        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
